// File: rtl/ws_matmul_stream_ctrl.sv
// Stream controller for a weight-stationary systolic array: loads weight rows,
// skews activation vectors onto the left edge and tracks output validity with tokens.
module ws_matmul_stream_ctrl #(
    parameter int ROWS      = 4,
    parameter int COLS      = 4,
    parameter int WORD_SIZE = 16,
    parameter int MAX_M     = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          reuse_w,
    input  logic [$clog2(MAX_M+1)-1:0]    m_len,
    input  logic                          w_valid,
    output logic                          w_ready,
    input  logic [COLS*WORD_SIZE-1:0]     w_data,
    input  logic                          a_valid,
    output logic                          a_ready,
    input  logic [ROWS*WORD_SIZE-1:0]     a_data,
    output logic                          set_stationary,
    output logic [COLS*WORD_SIZE-1:0]     top_in_bus,
    output logic [ROWS*WORD_SIZE-1:0]     left_in_bus,
    input  logic [COLS*WORD_SIZE-1:0]     bottom_out,
    output logic [COLS*WORD_SIZE-1:0]     out_data,
    output logic [COLS-1:0]               out_valid,
    output logic                          busy,
    output logic                          done
);

    localparam int MW = $clog2(MAX_M + 1);
    localparam int BW = $clog2(ROWS + 1);
    localparam int NT = ROWS + COLS;

    typedef enum logic [2:0] {S_IDLE, S_LOAD_W, S_STREAM, S_DRAIN, S_DONE} state_t;

    state_t                   state_q, state_d;
    logic [MW-1:0]            len_q, len_d, cnt_q, cnt_d;
    logic [BW-1:0]            beat_q, beat_d;
    logic                     loaded_q, loaded_d;
    logic [NT-1:0]            tok_q, tok_d;
    logic                     w_ready_q, w_ready_d, a_ready_q, a_ready_d;
    logic                     set_stat_q, set_stat_d, busy_q, busy_d, done_q, done_d;
    logic [COLS*WORD_SIZE-1:0] top_q, top_d;
    logic                     w_fire_s, a_fire_s;

    assign w_fire_s = w_valid && w_ready_q;
    assign a_fire_s = a_valid && a_ready_q;

    // Next-state, counters, token shift and registered handshake/status outputs.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        beat_d     = beat_q;
        loaded_d   = loaded_q;
        done_d     = 1'b0;
        tok_d      = {tok_q[NT-2:0], a_fire_s};
        top_d      = w_fire_s ? w_data : '0;
        set_stat_d = w_fire_s;
        case (state_q)
            S_IDLE: begin
                if (start && (m_len != '0) && (m_len <= MW'(MAX_M))) begin
                    len_d  = m_len;
                    cnt_d  = '0;
                    beat_d = '0;
                    // Reuse is only honoured once a complete weight load has landed.
                    if (reuse_w && loaded_q) begin
                        state_d = S_STREAM;
                    end else begin
                        state_d  = S_LOAD_W;
                        loaded_d = 1'b0;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD_W: begin
                if (w_fire_s) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == BW'(ROWS - 1)) begin
                        state_d  = S_STREAM;
                        loaded_d = 1'b1;
                    end else begin
                        state_d = S_LOAD_W;
                    end
                end else begin
                    state_d = S_LOAD_W;
                end
            end
            S_STREAM: begin
                if (a_fire_s) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == len_q) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_STREAM;
                    end
                end else begin
                    state_d = S_STREAM;
                end
            end
            S_DRAIN: begin
                if (tok_d == '0) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        w_ready_d = (state_d == S_LOAD_W);
        a_ready_d = (state_d == S_STREAM);
        busy_d    = (state_d != S_IDLE);
    end

    // Control state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            cnt_q      <= '0;
            beat_q     <= '0;
            loaded_q   <= 1'b0;
            tok_q      <= '0;
            w_ready_q  <= 1'b0;
            a_ready_q  <= 1'b0;
            set_stat_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            top_q      <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            beat_q     <= beat_d;
            loaded_q   <= loaded_d;
            tok_q      <= tok_d;
            w_ready_q  <= w_ready_d;
            a_ready_q  <= a_ready_d;
            set_stat_q <= set_stat_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            top_q      <= top_d;
        end
    end

    // Row r of the left edge sees its element r+1 cycles after acceptance.
    for (genvar r = 0; r < ROWS; r++) begin : g_skew
        logic [WORD_SIZE-1:0] pipe_q [r+1];
        logic [WORD_SIZE-1:0] pipe_d [r+1];

        // Per-row delay line; idle cycles push zeros.
        always_comb begin
            pipe_d[0] = a_fire_s ? a_data[r*WORD_SIZE +: WORD_SIZE] : '0;
            for (int k = 1; k <= r; k++) begin
                pipe_d[k] = pipe_q[k-1];
            end
        end

        // Delay-line storage.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int k = 0; k <= r; k++) begin
                    pipe_q[k] <= '0;
                end
            end else begin
                for (int k = 0; k <= r; k++) begin
                    pipe_q[k] <= pipe_d[k];
                end
            end
        end

        assign left_in_bus[r*WORD_SIZE +: WORD_SIZE] = pipe_q[r];
    end

    assign w_ready        = w_ready_q;
    assign a_ready        = a_ready_q;
    assign set_stationary = set_stat_q;
    assign top_in_bus     = top_q;
    assign out_valid      = tok_q[NT-1:ROWS];
    assign out_data       = bottom_out;
    assign busy           = busy_q;
    assign done           = done_q;

endmodule

// File: tb/tb_ws_matmul_stream_ctrl.sv
// Bench for ws_matmul_stream_ctrl (2x2 array, 8-bit words, MAX_M=4): job-level
// model with a cycle schedule, plus hand-computed timing expectations.
module tb_ws_matmul_stream_ctrl;

    localparam int ROWS = 2;
    localparam int COLS = 2;
    localparam int W    = 8;
    localparam int MAXM = 4;
    localparam int RING = 64;

    logic                 clk = 1'b0;
    logic                 rst, start, reuse_w, w_valid, a_valid;
    logic [2:0]           m_len;
    logic [COLS*W-1:0]    w_data, top_in_bus, bottom_out, out_data;
    logic [ROWS*W-1:0]    a_data, left_in_bus;
    logic                 w_ready, a_ready, set_stationary, busy, done;
    logic [COLS-1:0]      out_valid;

    ws_matmul_stream_ctrl #(.ROWS(ROWS), .COLS(COLS), .WORD_SIZE(W), .MAX_M(MAXM)) dut (
        .clk(clk), .rst(rst), .start(start), .reuse_w(reuse_w), .m_len(m_len),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
        .set_stationary(set_stationary), .top_in_bus(top_in_bus), .left_in_bus(left_in_bus),
        .bottom_out(bottom_out), .out_data(out_data), .out_valid(out_valid),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int total = 0;
    int bad = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) bottom_out <= 16'($urandom);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s cyc=%0d got=timeout want=event", name, cyc);
    endtask

    // Job-level model: remaining weight beats / vectors, completion cycle, and a schedule ring.
    int               job_on = 0, wleft = 0, aleft = 0, done_at = -1, loaded = 0;
    logic [COLS-1:0]  e_ov   [RING];
    logic [W-1:0]     e_left [RING][ROWS];
    logic             e_ss   [RING];
    logic [COLS*W-1:0] e_top [RING];
    logic [ROWS*W-1:0] e_lbus;
    logic             e_wr, e_ar;
    int               ov0_q[$], ov1_q[$], dn_q[$], hs_q[$];

    initial begin
        for (int i = 0; i < RING; i++) begin
            e_ov[i] = '0; e_ss[i] = 1'b0; e_top[i] = '0;
            for (int r = 0; r < ROWS; r++) e_left[i][r] = '0;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("reset_zero", {w_ready, a_ready, set_stationary, busy, done, out_valid,
                               top_in_bus, left_in_bus}, 64'd0);
            job_on = 0; loaded = 0; wleft = 0; aleft = 0; done_at = -1;
            for (int i = 0; i < RING; i++) begin
                e_ov[i] = '0; e_ss[i] = 1'b0; e_top[i] = '0;
                for (int r = 0; r < ROWS; r++) e_left[i][r] = '0;
            end
        end else begin
            e_wr = (job_on != 0) && (wleft > 0);
            e_ar = (job_on != 0) && (wleft == 0) && (aleft > 0);
            for (int r = 0; r < ROWS; r++) e_lbus[r*W +: W] = e_left[cyc % RING][r];
            chk("w_ready", w_ready, e_wr);
            chk("a_ready", a_ready, e_ar);
            chk("busy", busy, job_on != 0);
            chk("done", done, (job_on != 0) && (cyc == done_at));
            chk("set_stationary", set_stationary, e_ss[cyc % RING]);
            chk("top_in_bus", top_in_bus, e_top[cyc % RING]);
            chk("left_in_bus", left_in_bus, e_lbus);
            chk("out_valid", out_valid, e_ov[cyc % RING]);
            chk("out_data", out_data, bottom_out);
            if (out_valid[0]) ov0_q.push_back(cyc);
            if (out_valid[1]) ov1_q.push_back(cyc);
            if (done) dn_q.push_back(cyc);
            e_ov[cyc % RING] = '0; e_ss[cyc % RING] = 1'b0; e_top[cyc % RING] = '0;
            for (int r = 0; r < ROWS; r++) e_left[cyc % RING][r] = '0;
            if (e_wr && w_valid) begin
                e_ss[(cyc + 1) % RING]  = 1'b1;
                e_top[(cyc + 1) % RING] = w_data;
                wleft--;
                if (wleft == 0) loaded = 1;
            end
            if (e_ar && a_valid) begin
                for (int r = 0; r < ROWS; r++) e_left[(cyc + 1 + r) % RING][r] = a_data[r*W +: W];
                for (int c = 0; c < COLS; c++) e_ov[(cyc + ROWS + 1 + c) % RING][c] = 1'b1;
                hs_q.push_back(cyc);
                aleft--;
                if (aleft == 0) done_at = cyc + ROWS + COLS + 1;
            end
            if ((job_on != 0) && (cyc == done_at)) begin
                job_on = 0;
            end else if ((job_on == 0) && start && (m_len >= 1) && (m_len <= MAXM)) begin
                job_on  = 1;
                aleft   = int'(m_len);
                wleft   = (reuse_w && (loaded != 0)) ? 0 : ROWS;
                if (wleft != 0) loaded = 0;
                done_at = -1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic rw, input int m, output int s);
        s = cyc;
        start = 1'b1; reuse_w = rw; m_len = 3'(m);
        tick();
        start = 1'b0; reuse_w = 1'b0; m_len = '0;
    endtask

    task automatic send_w(input logic [COLS*W-1:0] d);
        int n;
        w_valid = 1'b1; w_data = d; n = 0;
        @(negedge clk);
        while (!w_ready && n < 40) begin @(negedge clk); n++; end
        if (n >= 40) timeout("w_handshake");
        tick();
        w_valid = 1'b0; w_data = '0;
    endtask

    task automatic send_a(input logic [ROWS*W-1:0] d, input int gap, output int hs);
        int n;
        a_valid = 1'b1; a_data = d; n = 0;
        @(negedge clk);
        while (!a_ready && n < 40) begin @(negedge clk); n++; end
        if (n >= 40) timeout("a_handshake");
        hs = cyc;
        tick();
        a_valid = 1'b0; a_data = '0;
        repeat (gap) tick();
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        @(negedge clk);
        while (!done && n < 60) begin @(negedge clk); n++; end
        if (n >= 60) timeout("done_wait");
        tick();
    endtask

    function automatic int qat(input int q[$], input int i);
        return (q.size() > i) ? q[i] : -1;
    endfunction

    task automatic clearq();
        ov0_q.delete(); ov1_q.delete(); dn_q.delete(); hs_q.delete();
    endtask

    int s, t0, t1, h;

    initial begin
        rst = 1'b1; start = 1'b0; reuse_w = 1'b0; m_len = '0;
        w_valid = 1'b0; w_data = '0; a_valid = 1'b0; a_data = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Job 1: load W (row [3,4] then [1,2]), two back-to-back vectors.
        clearq();
        do_start(1'b0, 2, s);
        send_w(16'h0403);
        send_w(16'h0201);
        send_a(16'h0101, 0, t0);
        send_a(16'h0002, 0, t1);
        wait_done();
        chk("j1_back_to_back", t1, t0 + 1);
        chk("j1_ov0_first", qat(ov0_q, 0), t0 + 3);
        chk("j1_ov0_second", qat(ov0_q, 1), t0 + 4);
        chk("j1_ov1_first", qat(ov1_q, 0), t0 + 4);
        chk("j1_ov1_second", qat(ov1_q, 1), t0 + 5);
        chk("j1_ov_count", ov0_q.size() + ov1_q.size(), 4);
        chk("j1_done_cycle", qat(dn_q, 0), t0 + 6);

        // Job 2: reuse weights, started in the cycle right after done.
        clearq();
        do_start(1'b1, 1, s);
        send_a(16'h0305, 0, h);
        wait_done();
        chk("j2_stream_next_cycle", h, s + 1);
        chk("j2_ov0_count", ov0_q.size(), 1);
        chk("j2_ov1_count", ov1_q.size(), 1);
        chk("j2_ov1_cycle", qat(ov1_q, 0), s + 5);

        // Job 3: two-cycle gap between vectors.
        clearq();
        do_start(1'b1, 2, s);
        send_a(16'h0a0b, 2, t0);
        send_a(16'h0c0d, 0, t1);
        wait_done();
        chk("j3_gap_hs", t1, t0 + 3);
        chk("j3_ov0_a", qat(ov0_q, 0), t0 + 3);
        chk("j3_ov0_b", qat(ov0_q, 1), t0 + 6);
        chk("j3_ov1_a", qat(ov1_q, 0), t0 + 4);
        chk("j3_ov1_b", qat(ov1_q, 1), t0 + 7);
        chk("j3_ov_count", ov0_q.size() + ov1_q.size(), 4);

        // Ignored starts: zero length and over-length.
        clearq();
        do_start(1'b0, 0, s);
        @(negedge clk);
        chk("ign_len0_busy", busy, 1'b0);
        tick();
        do_start(1'b1, 5, s);
        @(negedge clk);
        chk("ign_len5_busy", busy, 1'b0);
        tick();

        // Job 4: MAX_M continuous vectors, with a stray start while busy.
        clearq();
        do_start(1'b1, MAXM, s);
        send_a(16'h0101, 0, h);
        send_a(16'h0202, 0, h);
        start = 1'b1; m_len = 3'd1;
        send_a(16'h0303, 0, h);
        start = 1'b0; m_len = '0;
        send_a(16'h0404, 0, h);
        wait_done();
        repeat (3) tick();
        chk("j4_ov0_count", ov0_q.size(), MAXM);
        chk("j4_ov1_count", ov1_q.size(), MAXM);
        chk("j4_single_done", dn_q.size(), 1);

        // Job 5: async reset mid-stream, then reuse request must reload.
        clearq();
        do_start(1'b1, 3, s);
        send_a(16'h0707, 0, h);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_outputs", {w_ready, a_ready, set_stationary, busy, done, out_valid,
                                  top_in_bus, left_in_bus}, 64'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        do_start(1'b1, 1, s);
        @(negedge clk);
        chk("reload_w_ready", w_ready, 1'b1);
        tick();
        send_w(16'h0605);
        send_w(16'h0807);
        send_a(16'h0109, 0, h);
        wait_done();
        chk("j5_done_count", dn_q.size(), 1);

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ws_matmul_stream_ctrl.md
WS_MATMUL_STREAM_CTRL -- requirements
Module: ws_matmul_stream_ctrl

Interface
REQ-001 SHALL have parameter ROWS, default 4, meaning systolic array rows (K dimension).
REQ-002 SHALL have parameter COLS, default 4, meaning systolic array columns (N dimension).
REQ-003 SHALL have parameter WORD_SIZE, default 16, meaning data word width.
REQ-004 SHALL have parameter MAX_M, default 16, meaning maximum activation vectors per job.
REQ-005 clk  in  1  sole clock; all state changes on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 start  in  1  job request pulse.
REQ-008 reuse_w  in  1  sampled with start; 1 = skip weight load and keep stationary weights.
REQ-009 m_len  in  $clog2(MAX_M+1)  activation vector count, sampled with start.
REQ-010 w_valid / w_ready  in / out  1 each  weight-row handshake.
REQ-011 w_data  in  COLS*WORD_SIZE  one weight row.
REQ-012 a_valid / a_ready  in / out  1 each  activation handshake.
REQ-013 a_data  in  ROWS*WORD_SIZE  one activation vector, element r at bits [r*WORD_SIZE +: WORD_SIZE].
REQ-014 set_stationary  out  1  array shifts top_in_bus into stationary registers this cycle.
REQ-015 top_in_bus  out  COLS*WORD_SIZE  weight row to array top.
REQ-016 left_in_bus  out  ROWS*WORD_SIZE  skewed activations to array left edge.
REQ-017 bottom_out  in  COLS*WORD_SIZE  array bottom outputs.
REQ-018 out_data  out  COLS*WORD_SIZE  equals bottom_out, combinational pass-through.
REQ-019 out_valid  out  COLS  bit c = out_data column c valid this cycle.
REQ-020 busy  out  1  high in every state except IDLE.
REQ-021 done  out  1  one-cycle pulse on job completion.

Function
REQ-022 SHALL implement states IDLE, LOAD_W, STREAM, DRAIN, DONE.
REQ-023 IDLE: start=1 with m_len in 1..MAX_M -> LOAD_W if reuse_w=0, else STREAM; start with m_len=0 or m_len>MAX_M ignored, stays IDLE; start outside IDLE ignored.
REQ-024 LOAD_W: w_ready=1; each w_valid&&w_ready registers w_data onto top_in_bus and asserts set_stationary for exactly the following cycle; otherwise set_stationary=0 and top_in_bus=0.
REQ-025 First accepted weight beat SHALL end in array row ROWS-1, last in row 0; after ROWS beats -> STREAM.
REQ-026 STREAM: a_ready=1 until m_len vectors accepted; a_valid=0 cycles insert zero bubbles with no output validity.
REQ-027 Vector accepted at edge T: element r SHALL appear on left_in_bus row r during cycle T+1+r; rows carry 0 when no valid element is scheduled.
REQ-028 Accepted vector SHALL assert out_valid[c] exactly during cycle T+ROWS+1+c, one cycle per column per vector.
REQ-029 Validity SHALL be tracked by a token shift register of length ROWS+COLS; bubbles propagate as zero tokens.
REQ-030 After m_len-th acceptance -> DRAIN with a_ready=0; DRAIN -> DONE when all tokens cleared; DONE asserts done for one cycle -> IDLE.
REQ-031 Back-to-back jobs: start in the cycle after done SHALL be accepted; stationary weights persist across jobs until reloaded.
REQ-032 Acceptance counter width $clog2(MAX_M+1); SHALL never wrap; m_len=MAX_M completes normally.
REQ-033 w_ready and a_ready SHALL never be high simultaneously.

Reset
REQ-034 rst=1 SHALL immediately force IDLE, clear counters and tokens, and set w_ready, a_ready, set_stationary, out_valid, busy, done to 0 and top_in_bus, left_in_bus to 0.
REQ-035 Reset mid-job SHALL discard the job; stationary weight state marked invalid, and reuse_w=1 start before any completed load SHALL be treated as reuse_w=0.

Verification (ROWS=COLS=2, WORD_SIZE=8)
REQ-036 Load W=[[1,2],[3,4]] (beats [3,4] then [1,2]), m_len=2, vectors [1,1],[2,0] back-to-back -> out_valid[0] cycles T0+3,T0+4, out_valid[1] T0+4,T0+5; done 1 cycle after last token clears.
REQ-037 a_valid gap of 2 cycles between vectors -> out_valid pulses separated by 3 cycles per column, no spurious pulses.
REQ-038 Second job reuse_w=1, m_len=1 -> no w_ready, STREAM entered next cycle, one out_valid pulse per column.
REQ-039 Async rst asserted mid-STREAM between edges -> all outputs 0 before next edge; following reuse_w=1 start performs LOAD_W.
REQ-040 start with m_len=0 and start while busy -> ignored, busy/done unchanged.
REQ-041 m_len=MAX_M continuous stream -> exactly MAX_M pulses per column, single done.
